// File: rtl/system_timer_host.sv
// system_timer_host: Avalon-MM host for the 16-bit interval-timer slave.
// On start it programs the 32-bit period and launches the timer in
// continuous, interrupt-enabled mode, then services every irq by reading
// and clearing the status register, counting each serviced timeout.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, stop, period     command port (one-cycle requests, reload value)
//   busy, running           FSM activity / timer-launched status
//   tick, tick_count        one-cycle pulse and wrapping count per timeout
//   address, chipselect,    Avalon-MM host signals (all registered,
//   write_n, writedata,     single-cycle accesses, no wait states)
//   readdata, irq           slave read data (registered by slave), interrupt
module system_timer_host #(
  parameter int unsigned TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  input  logic              irq
);

  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_PL    = 4'd1;
  localparam logic [3:0] S_WR_PH    = 4'd2;
  localparam logic [3:0] S_WR_CTRL  = 4'd3;
  localparam logic [3:0] S_WAIT_IRQ = 4'd4;
  localparam logic [3:0] S_RD_STAT  = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_CLR      = 4'd7;
  localparam logic [3:0] S_WR_STOP  = 4'd8;

  localparam logic [ADDR_W-1:0] A_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] A_CONTROL  = 3'd1;
  localparam logic [ADDR_W-1:0] A_PERIOD_L = 3'd2;
  localparam logic [ADDR_W-1:0] A_PERIOD_H = 3'd3;

  localparam logic [DATA_W-1:0] CTRL_START = 16'h0007; // START|CONT|ITO
  localparam logic [DATA_W-1:0] CTRL_STOP  = 16'h0008;

  logic [3:0]          state, state_nxt;
  logic [PERIOD_W-1:0] period_q, period_nxt;
  logic                stop_pending, stop_pending_nxt;
  logic                busy_nxt, running_nxt, tick_nxt;
  logic [TICK_W-1:0]   tick_count_nxt;
  logic [ADDR_W-1:0]   address_nxt;
  logic                chipselect_nxt, write_n_nxt;
  logic [DATA_W-1:0]   writedata_nxt;

  // Only the TO flag of the status register matters here.
  logic unused_readdata;
  assign unused_readdata = ^readdata[15:1];

  // Next state, bookkeeping, and bus outputs decoded from the next state so
  // that each access appears on the bus in the cycle its state is occupied.
  always_comb begin
    state_nxt        = state;
    period_nxt       = period_q;
    stop_pending_nxt = stop_pending;
    running_nxt      = running;
    tick_nxt         = 1'b0;
    tick_count_nxt   = tick_count;
    chipselect_nxt   = 1'b0;
    write_n_nxt      = 1'b1;
    address_nxt      = A_STATUS;
    writedata_nxt    = '0;

    if (stop && (state != S_IDLE) && (state != S_WAIT_IRQ)) begin
      stop_pending_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          period_nxt = (period == 32'd0) ? 32'd1 : period;
          state_nxt  = S_WR_PL;
        end
      end
      S_WR_PL:   state_nxt = S_WR_PH;
      S_WR_PH:   state_nxt = S_WR_CTRL;
      S_WR_CTRL: begin
        state_nxt   = S_WAIT_IRQ;
        running_nxt = 1'b1;
      end
      S_WAIT_IRQ: begin
        if (irq) begin
          state_nxt = S_RD_STAT;
          // A stop colliding with an interrupt waits for the service to end.
          if (stop) stop_pending_nxt = 1'b1;
        end else if (stop || stop_pending) begin
          state_nxt = S_WR_STOP;
        end
      end
      S_RD_STAT: state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = readdata[0] ? S_CLR : S_WAIT_IRQ;
      S_CLR: begin
        state_nxt      = S_WAIT_IRQ;
        tick_nxt       = 1'b1;
        tick_count_nxt = tick_count + TICK_W'(1);
      end
      S_WR_STOP: begin
        state_nxt        = S_IDLE;
        running_nxt      = 1'b0;
        stop_pending_nxt = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_WR_PL: begin
        chipselect_nxt = 1'b1;
        write_n_nxt    = 1'b0;
        address_nxt    = A_PERIOD_L;
        writedata_nxt  = period_nxt[15:0];
      end
      S_WR_PH: begin
        chipselect_nxt = 1'b1;
        write_n_nxt    = 1'b0;
        address_nxt    = A_PERIOD_H;
        writedata_nxt  = period_nxt[31:16];
      end
      S_WR_CTRL: begin
        chipselect_nxt = 1'b1;
        write_n_nxt    = 1'b0;
        address_nxt    = A_CONTROL;
        writedata_nxt  = CTRL_START;
      end
      S_RD_STAT: begin
        chipselect_nxt = 1'b1;
        address_nxt    = A_STATUS;
      end
      S_CLR: begin
        chipselect_nxt = 1'b1;
        write_n_nxt    = 1'b0;
        address_nxt    = A_STATUS;
      end
      S_WR_STOP: begin
        chipselect_nxt = 1'b1;
        write_n_nxt    = 1'b0;
        address_nxt    = A_CONTROL;
        writedata_nxt  = CTRL_STOP;
      end
      default: ;
    endcase

    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_WAIT_IRQ);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      period_q     <= '0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      running      <= 1'b0;
      tick         <= 1'b0;
      tick_count   <= '0;
      address      <= '0;
      chipselect   <= 1'b0;
      write_n      <= 1'b1;
      writedata    <= '0;
    end else begin
      state        <= state_nxt;
      period_q     <= period_nxt;
      stop_pending <= stop_pending_nxt;
      busy         <= busy_nxt;
      running      <= running_nxt;
      tick         <= tick_nxt;
      tick_count   <= tick_count_nxt;
      address      <= address_nxt;
      chipselect   <= chipselect_nxt;
      write_n      <= write_n_nxt;
      writedata    <= writedata_nxt;
    end
  end

endmodule

// File: tb/tb_system_timer_host.sv
// Testbench for system_timer_host: a small interval-timer slave model, a
// randomized stimulus process that pushes expected bus accesses, ticks and
// status samples into queues, and a monitor that pops and compares them.
// tick_count is narrowed so that its wrap-around is reachable quickly.
module tb_system_timer_host;

  localparam int unsigned CW      = 8;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
  localparam int unsigned LIMIT   = 20000;

  typedef struct {
    bit          is_tick;
    logic [2:0]  addr;
    bit          wr;
    logic [15:0] data;
    int unsigned cyc;
    logic [CW-1:0] cnt;
  } ev_t;

  typedef struct {
    int unsigned cyc;
    bit          running;
    bit          busy;
    logic [CW-1:0] cnt;
    bit          rst_chk;
  } st_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop;
  logic [31:0]   period;
  logic          busy, running, tick;
  logic [CW-1:0] tick_count;
  logic [2:0]    address;
  logic          chipselect, write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic          irq;

  // slave model state and test controls
  logic        to_flag, run_bit;
  logic        raise_to, spur_irq;
  bit          done = 1'b0;
  int unsigned cyc = 0;
  int unsigned model_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         q_ev[$];
  st_t         q_st[$];

  system_timer_host #(.TICK_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .busy       (busy),
    .running    (running),
    .tick       (tick),
    .tick_count (tick_count),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: registered readdata, TO flag set by the test, cleared by
  // a write to status; RUN bit follows control START/STOP writes.
  assign irq = to_flag | spur_irq;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_flag  <= 1'b0;
      run_bit  <= 1'b0;
      readdata <= 16'h0;
    end else begin
      readdata <= (chipselect && write_n && address == 3'd0) ?
                  {14'd0, run_bit, to_flag} : 16'h0;
      if (chipselect && !write_n && address == 3'd0) to_flag <= 1'b0;
      else if (raise_to) to_flag <= 1'b1;
      if (chipselect && !write_n && address == 3'd1) begin
        if (writedata[2]) run_bit <= 1'b1;
        if (writedata[3]) run_bit <= 1'b0;
      end
    end
  end

  // Monitor: compares every bus access, tick pulse and scheduled status sample.
  always @(negedge clk) begin
    ev_t e;
    st_t s;
    if (chipselect) begin
      checks++;
      if (q_ev.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected cyc=%0d addr=%0d wr=%0b data=%h", cyc, address, ~write_n, writedata);
      end else begin
        e = q_ev.pop_front();
        if (e.is_tick || e.addr !== address || e.wr !== ~write_n ||
            (e.wr && e.data !== writedata) || e.cyc != cyc) begin
          errors++;
          $display("FAIL bus_access got addr=%0d wr=%0b data=%h cyc=%0d, want tick=%0b addr=%0d wr=%0b data=%h cyc=%0d",
                   address, ~write_n, writedata, cyc, e.is_tick, e.addr, e.wr, e.data, e.cyc);
        end
      end
    end
    if (tick) begin
      checks++;
      if (q_ev.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected cyc=%0d count=%0d", cyc, tick_count);
      end else begin
        e = q_ev.pop_front();
        if (!e.is_tick || e.cyc != cyc || tick_count !== e.cnt) begin
          errors++;
          $display("FAIL tick_event got cyc=%0d count=%0d, want tick=%0b cyc=%0d count=%0d",
                   cyc, tick_count, e.is_tick, e.cyc, e.cnt);
        end
      end
    end
    while (q_st.size() > 0 && q_st[0].cyc <= cyc) begin
      s = q_st.pop_front();
      checks++;
      if (s.cyc != cyc || running !== s.running || busy !== s.busy || tick_count !== s.cnt ||
          (s.rst_chk && (chipselect !== 1'b0 || write_n !== 1'b1 || address !== 3'd0 ||
                         writedata !== 16'h0 || tick !== 1'b0))) begin
        errors++;
        $display("FAIL status cyc=%0d (want %0d) running=%b busy=%b count=%0d cs=%b wn=%b addr=%0d wd=%h tick=%b, want running=%b busy=%b count=%0d rst=%b",
                 cyc, s.cyc, running, busy, tick_count, chipselect, write_n, address, writedata, tick,
                 s.running, s.busy, s.cnt, s.rst_chk);
      end
    end
    if (done || cyc > LIMIT) begin
      checks++;
      if (cyc > LIMIT) begin
        errors++;
        $display("FAIL timeout cyc=%0d limit=%0d", cyc, LIMIT);
      end else if (q_ev.size() != 0 || q_st.size() != 0) begin
        errors++;
        $display("FAIL leftover events=%0d status=%0d, want 0 and 0", q_ev.size(), q_st.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [2:0] a, input logic [15:0] d, input bit w, input int unsigned c);
    ev_t e;
    e.is_tick = 1'b0; e.addr = a; e.wr = w; e.data = d; e.cyc = c; e.cnt = '0;
    q_ev.push_back(e);
  endtask

  task automatic push_tick(input int unsigned c);
    ev_t e;
    model_cnt = (model_cnt + 1) % (CNT_MAX + 1);
    e.is_tick = 1'b1; e.addr = '0; e.wr = 1'b0; e.data = '0; e.cyc = c; e.cnt = CW'(model_cnt);
    q_ev.push_back(e);
  endtask

  task automatic push_stat(input int unsigned c, input bit r, input bit b, input bit rc);
    st_t s;
    s.cyc = c; s.running = r; s.busy = b; s.cnt = CW'(model_cnt); s.rst_chk = rc;
    q_st.push_back(s);
  endtask

  // start from IDLE; optionally request stop while the timer is being programmed
  task automatic do_start(input logic [31:0] p, input bit stop_early);
    int unsigned c0;
    logic [31:0] pe;
    step();
    c0 = cyc;
    start = 1'b1;
    period = p;
    pe = (p == 32'd0) ? 32'd1 : p;
    push_bus(3'd2, pe[15:0], 1'b1, c0 + 1);
    push_bus(3'd3, pe[31:16], 1'b1, c0 + 2);
    push_bus(3'd1, 16'h0007, 1'b1, c0 + 3);
    push_stat(c0 + 1, 1'b0, 1'b1, 1'b0);
    push_stat(c0 + 4, 1'b1, 1'b0, 1'b0);
    step();
    start = 1'b0;
    period = $urandom;
    if (stop_early) begin
      stop = 1'b1;
      push_bus(3'd1, 16'h0008, 1'b1, c0 + 5);
      push_stat(c0 + 6, 1'b0, 1'b0, 1'b0);
    end
    step();
    stop = 1'b0;
    while (cyc < c0 + (stop_early ? 6 : 4)) step();
  endtask

  // one real timeout; optionally stop while the status read is returning
  task automatic service(input bit stop_mid);
    int unsigned k;
    step();
    raise_to = 1'b1;
    step();
    raise_to = 1'b0;
    k = cyc;
    push_bus(3'd0, 16'h0, 1'b0, k + 1);
    push_bus(3'd0, 16'h0, 1'b1, k + 3);
    push_tick(k + 4);
    push_stat(k + 4, 1'b1, 1'b0, 1'b0);
    if (stop_mid) begin
      push_bus(3'd1, 16'h0008, 1'b1, k + 5);
      push_stat(k + 6, 1'b0, 1'b0, 1'b0);
    end
    step();
    step();
    if (stop_mid) stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    if (stop_mid) begin
      step();
      step();
    end
  endtask

  // irq without TO set: read only, back to waiting
  task automatic spurious();
    int unsigned k;
    step();
    k = cyc;
    spur_irq = 1'b1;
    push_bus(3'd0, 16'h0, 1'b0, k + 1);
    push_stat(k + 3, 1'b1, 1'b0, 1'b0);
    step();
    spur_irq = 1'b0;
    step();
    step();
  endtask

  task automatic stop_wait();
    int unsigned j;
    step();
    j = cyc;
    stop = 1'b1;
    push_bus(3'd1, 16'h0008, 1'b1, j + 1);
    push_stat(j + 2, 1'b0, 1'b0, 1'b0);
    step();
    stop = 1'b0;
    step();
  endtask

  // a command that must be ignored in the current state
  task automatic ignored_pulse(input bit is_start, input bit run_now);
    step();
    if (is_start) begin
      start = 1'b1;
      period = $urandom;
    end else begin
      stop = 1'b1;
    end
    push_stat(cyc + 1, run_now, 1'b0, 1'b0);
    push_stat(cyc + 3, run_now, 1'b0, 1'b0);
    step();
    start = 1'b0;
    stop = 1'b0;
    step();
    step();
  endtask

  initial begin
    int unsigned c0;
    int unsigned r;
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    period = 32'h0;
    raise_to = 1'b0;
    spur_irq = 1'b0;
    step();
    push_stat(cyc, 1'b0, 1'b0, 1'b1);
    step();
    reset_n = 1'b1;
    push_stat(cyc, 1'b0, 1'b0, 1'b1);
    step();

    do_start(32'h0001_86A0, 1'b0);
    repeat (3) begin
      service(1'b0);
      repeat ($urandom_range(0, 2)) step();
    end
    spurious();
    service(1'b1);
    ignored_pulse(1'b0, 1'b0);
    do_start(32'h0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 3);
      if (r < 2) service(1'b0);
      else if (r == 2) spurious();
      else ignored_pulse(1'b1, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    while (model_cnt != CNT_MAX) service(1'b0);
    service(1'b0);
    stop_wait();
    do_start($urandom, 1'b1);

    // reset while the period high half is on the bus
    step();
    c0 = cyc;
    start = 1'b1;
    period = 32'h1234_5678;
    push_bus(3'd2, 16'h5678, 1'b1, c0 + 1);
    step();
    start = 1'b0;
    step();
    #1;
    reset_n = 1'b0;
    model_cnt = 0;
    push_stat(c0 + 2, 1'b0, 1'b0, 1'b1);
    step();
    step();
    reset_n = 1'b1;
    step();
    do_start($urandom, 1'b0);
    service(1'b0);
    stop_wait();

    repeat (5) step();
    done = 1'b1;
    repeat (5) step();
  end

endmodule
